// File: rtl/decrypted_checker.sv
// Scans the decrypted RAM and reports whether every byte is 'a'..'z' or a space.
// Two cycles per byte (address, then judge); stops at the first rejected byte.
module decrypted_checker #(
  parameter int MESSAGE_LENGTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] q,
  output logic [7:0] address,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic [7:0] bad_index
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SET_ADDR = 3'd1;
  localparam logic [2:0] CHECK    = 3'd2;
  localparam logic [2:0] PASS     = 3'd3;
  localparam logic [2:0] FAIL     = 3'd4;

  // End test at 9 bits so MESSAGE_LENGTH=256 ends at k=255 without overflow.
  localparam logic [8:0] LAST_IDX = 9'(MESSAGE_LENGTH - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] k_q, k_d;
  logic       valid_q, valid_d;
  logic [7:0] bad_q, bad_d;
  logic       q_ok;

  assign q_ok = (q == 8'd32) || (q >= 8'd97 && q <= 8'd122);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    valid_d = valid_q;
    bad_d   = bad_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = 8'd0;
          valid_d = 1'b0;
          bad_d   = 8'd0;
          state_d = SET_ADDR;
        end
      end
      SET_ADDR: state_d = CHECK;
      CHECK: begin
        if (!q_ok) begin
          state_d = FAIL;
        end else if ({1'b0, k_q} == LAST_IDX) begin
          state_d = PASS;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = SET_ADDR;
        end
      end
      PASS: begin
        valid_d = 1'b1;
        state_d = IDLE;
      end
      FAIL: begin
        // k still holds the offending index; publish it with the verdict.
        valid_d = 1'b0;
        bad_d   = k_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 8'd0;
      valid_q <= 1'b0;
      bad_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    case (state_q)
      SET_ADDR, CHECK: address = k_q;
      default:         address = 8'd0;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == PASS) || (state_q == FAIL);
  assign valid     = valid_q;
  assign bad_index = bad_q;

endmodule
